// File: rtl/stratigo_pkg.sv
// Shared constants, encodings and helpers for the stratigo board datapath.
package stratigo_pkg;

    localparam int unsigned CELL_W    = 6;
    localparam int unsigned BOARD_N   = 8;
    localparam int unsigned NUM_CELLS = BOARD_N * BOARD_N;
    localparam int unsigned BOARD_W   = CELL_W * NUM_CELLS;
    localparam int unsigned COORD_W   = 3;
    localparam int unsigned OFF_W     = 9;

    localparam logic [4:0] U_BLANK = 5'd0;
    localparam logic [4:0] U_F     = 5'd1;
    localparam logic [4:0] U_G     = 5'd2;
    localparam logic [4:0] U_H     = 5'd3;
    localparam logic [4:0] U_I     = 5'd4;
    localparam logic [4:0] U_J     = 5'd5;
    localparam logic [4:0] U_K     = 5'd6;
    localparam logic [4:0] U_L     = 5'd7;
    localparam logic [4:0] U_M     = 5'd8;
    localparam logic [4:0] U_N     = 5'd9;
    localparam logic [4:0] U_NMOVE = 5'h1F;

    localparam logic [CELL_W-1:0] CELL_BLANK = {U_BLANK, 1'b0};
    localparam logic [CELL_W-1:0] CELL_LAKE  = {U_NMOVE, 1'b1};

    typedef enum logic [1:0] {
        CMD_CAPTURE = 2'b00,
        CMD_DIE     = 2'b01,
        CMD_TRADE   = 2'b10,
        CMD_PLACE   = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Lakes at (2,3), (5,3), (2,4), (5,4); entry 0 is the rightmost field.
    localparam logic [3:0][COORD_W-1:0] LAKE_X = {3'd5, 3'd2, 3'd5, 3'd2};
    localparam logic [3:0][COORD_W-1:0] LAKE_Y = {3'd4, 3'd4, 3'd3, 3'd3};

    // Bit offset of cell (x,y): CELL_W * (x + 8*y).
    function automatic logic [OFF_W-1:0] cell_off(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return OFF_W'(CELL_W) * OFF_W'({y, x});
    endfunction

    function automatic logic [BOARD_W-1:0] reset_board();
        logic [BOARD_W-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            b[cell_off(LAKE_X[2'(i)], LAKE_Y[2'(i)]) +: CELL_W] = CELL_LAKE;
        end
        return b;
    endfunction

endpackage

// File: rtl/move_executor_if.sv
// Command/status bundle between a requester and the move executor.
interface move_executor_if;
    import stratigo_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              command;
    logic [COORD_W-1:0]      src_x;
    logic [COORD_W-1:0]      src_y;
    logic [COORD_W-1:0]      dst_x;
    logic [COORD_W-1:0]      dst_y;
    logic [CELL_W-1:0]       place_piece;
    logic                    clear_win;
    logic [BOARD_W-1:0]      board;
    logic                    done;
    logic                    error;
    logic                    win_flag;
    logic                    win_team;

    modport master (
        output cmd_valid, command, src_x, src_y, dst_x, dst_y, place_piece, clear_win,
        input  cmd_ready, board, done, error, win_flag, win_team
    );

    modport slave (
        input  cmd_valid, command, src_x, src_y, dst_x, dst_y, place_piece, clear_win,
        output cmd_ready, board, done, error, win_flag, win_team
    );

endinterface

// File: rtl/move_executor.sv
// Executes one board command per 4-cycle IDLE/READ/WRITE/DONE pass and
// tracks the sticky flag-capture status.
module move_executor
    import stratigo_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    move_executor_if.slave  bus
);

    state_t               r_state;
    state_t               w_next;
    cmd_t                 r_cmd;
    logic [COORD_W-1:0]   r_sx, r_sy, r_dx, r_dy;
    logic [CELL_W-1:0]    r_piece;
    logic [CELL_W-1:0]    r_src_cell, r_dst_cell;
    logic                 r_illegal;
    logic [BOARD_W-1:0]   r_board;
    logic                 r_cmd_ready;
    logic                 r_done, r_error;
    logic                 r_win_flag, r_win_team;

    logic                 w_accept;
    logic [OFF_W-1:0]     w_src_off, w_dst_off;
    logic [CELL_W-1:0]    w_src_rd, w_dst_rd;
    logic                 w_illegal;
    logic                 w_apply;

    assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
    assign w_src_off = cell_off(r_sx, r_sy);
    assign w_dst_off = cell_off(r_dx, r_dy);
    assign w_src_rd  = r_board[w_src_off +: CELL_W];
    assign w_dst_rd  = r_board[w_dst_off +: CELL_W];
    assign w_apply   = (r_state == S_WRITE) && !r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_READ;
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
        endcase
    end

    // PLACE only needs an empty target; lake cells are non-blank so they fail too.
    always_comb begin
        w_illegal = 1'b0;
        if (r_cmd == CMD_PLACE) begin
            w_illegal = (w_dst_rd != CELL_BLANK);
        end else begin
            w_illegal = ({r_sx, r_sy} == {r_dx, r_dy})
                     || (w_src_rd == CELL_BLANK) || (w_src_rd == CELL_LAKE)
                     || (w_dst_rd == CELL_LAKE)
                     || ((w_dst_rd != CELL_BLANK) && (w_src_rd[0] == w_dst_rd[0]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd       <= CMD_CAPTURE;
            r_sx        <= '0;
            r_sy        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_piece     <= '0;
            r_src_cell  <= '0;
            r_dst_cell  <= '0;
            r_illegal   <= 1'b0;
            r_board     <= reset_board();
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next == S_IDLE);
            r_done      <= (r_state == S_WRITE);
            r_error     <= (r_state == S_WRITE) && r_illegal;
            if (w_accept) begin
                r_cmd   <= cmd_t'(bus.command);
                r_sx    <= bus.src_x;
                r_sy    <= bus.src_y;
                r_dx    <= bus.dst_x;
                r_dy    <= bus.dst_y;
                r_piece <= bus.place_piece;
            end
            if (r_state == S_READ) begin
                r_src_cell <= w_src_rd;
                r_dst_cell <= w_dst_rd;
                r_illegal  <= w_illegal;
            end
            if (w_apply) begin
                case (r_cmd)
                    CMD_CAPTURE: begin
                        r_board[w_dst_off +: CELL_W] <= r_src_cell;
                        r_board[w_src_off +: CELL_W] <= CELL_BLANK;
                    end
                    CMD_DIE: r_board[w_src_off +: CELL_W] <= CELL_BLANK;
                    CMD_TRADE: begin
                        r_board[w_src_off +: CELL_W] <= CELL_BLANK;
                        r_board[w_dst_off +: CELL_W] <= CELL_BLANK;
                    end
                    CMD_PLACE: r_board[w_dst_off +: CELL_W] <= r_piece;
                endcase
            end
        end
    end

    // First flag capture wins; clear_win overrides a same-edge set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_flag <= 1'b0;
            r_win_team <= 1'b0;
        end else if (bus.clear_win) begin
            r_win_flag <= 1'b0;
            r_win_team <= 1'b0;
        end else if (w_apply && (r_cmd == CMD_CAPTURE) &&
                     (r_dst_cell[CELL_W-1:1] == U_F) && !r_win_flag) begin
            r_win_flag <= 1'b1;
            r_win_team <= r_src_cell[0];
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.board     = r_board;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.win_flag  = r_win_flag;
    assign bus.win_team  = r_win_team;

endmodule

// File: tb/tb_move_executor.sv
// Randomized self-checking bench for move_executor against a cell-array model.
module tb_move_executor;
    import stratigo_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    move_executor_if bus();
    move_executor dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] m_cell [64];
    bit         m_wf, m_wt;

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [383:0] m_flat();
        logic [383:0] r;
        for (int i = 0; i < 64; i++) r[6*i +: 6] = m_cell[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_cell[i] = 6'd0;
        m_cell[2 + 8*3] = 6'b111111;
        m_cell[5 + 8*3] = 6'b111111;
        m_cell[2 + 8*4] = 6'b111111;
        m_cell[5 + 8*4] = 6'b111111;
        m_wf = 1'b0;
        m_wt = 1'b0;
    endtask

    // Rules as written: legality first, then the cell rewrite and flag status.
    task automatic m_apply(input logic [1:0] cmd, input logic [2:0] sx, sy, dx, dy,
                           input logic [5:0] pp, output bit err);
        int s, d;
        logic [5:0] sc, dc;
        s  = int'(sx) + 8 * int'(sy);
        d  = int'(dx) + 8 * int'(dy);
        sc = m_cell[s];
        dc = m_cell[d];
        if (cmd == 2'b11) begin
            err = (dc != 6'd0);
            if (!err) m_cell[d] = pp;
        end else begin
            err = (s == d) || (sc == 6'd0) || (sc == 6'd63) || (dc == 6'd63) ||
                  (dc != 6'd0 && sc[0] == dc[0]);
            if (!err) begin
                if (cmd == 2'b00) begin
                    if (dc[5:1] == 5'd1 && !m_wf) begin
                        m_wf = 1'b1;
                        m_wt = sc[0];
                    end
                    m_cell[d] = sc;
                    m_cell[s] = 6'd0;
                end else if (cmd == 2'b01) begin
                    m_cell[s] = 6'd0;
                end else begin
                    m_cell[s] = 6'd0;
                    m_cell[d] = 6'd0;
                end
            end
        end
    endtask

    task automatic drive_garbage();
        bus.command     = 2'($urandom);
        bus.src_x       = 3'($urandom);
        bus.src_y       = 3'($urandom);
        bus.dst_x       = 3'($urandom);
        bus.dst_y       = 3'($urandom);
        bus.place_piece = 6'($urandom);
    endtask

    task automatic do_cmd(input logic [1:0] cmd, input logic [2:0] sx, sy, dx, dy,
                          input logic [5:0] pp, input bit hold, input bit clr_w);
        bit err;
        @(negedge clk);
        check("ready_idle", 384'(bus.cmd_ready), 384'(1'b1));
        bus.cmd_valid   = 1'b1;
        bus.command     = cmd;
        bus.src_x       = sx;
        bus.src_y       = sy;
        bus.dst_x       = dx;
        bus.dst_y       = dy;
        bus.place_piece = pp;
        bus.clear_win   = 1'b0;
        @(posedge clk);
        m_apply(cmd, sx, sy, dx, dy, pp, err);
        if (clr_w) begin
            m_wf = 1'b0;
            m_wt = 1'b0;
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (!hold) bus.cmd_valid = 1'b0;
            drive_garbage();
            bus.clear_win = clr_w && (k == 2);
            check("busy_ready", 384'(bus.cmd_ready), 384'(1'b0));
            check("done_timing", 384'(bus.done), 384'(k == 3));
            if (k == 3) begin
                check("error", 384'(bus.error), 384'(err));
                check("board", bus.board, m_flat());
                check("win_flag", 384'(bus.win_flag), 384'(m_wf));
                check("win_team", 384'(bus.win_team), 384'(m_wt));
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.clear_win = 1'b1;
        @(negedge clk);
        bus.clear_win = 1'b0;
        m_wf = 1'b0;
        m_wt = 1'b0;
        check("clr_flag", 384'(bus.win_flag), 384'(1'b0));
        check("clr_team", 384'(bus.win_team), 384'(1'b0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_board"}, bus.board, m_flat());
        check({tag, "_ready"}, 384'(bus.cmd_ready), 384'(1'b1));
        check({tag, "_done"},  384'(bus.done), 384'(1'b0));
        check({tag, "_error"}, 384'(bus.error), 384'(1'b0));
        check({tag, "_wflag"}, 384'(bus.win_flag), 384'(1'b0));
        check({tag, "_wteam"}, 384'(bus.win_team), 384'(1'b0));
    endtask

    // phase 0 asserts reset during READ, phase 1 during WRITE.
    task automatic do_reset_mid(input bit phase, input logic [2:0] sx, sy, dx, dy);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.command   = 2'b00;
        bus.src_x     = sx;
        bus.src_y     = sy;
        bus.dst_x     = dx;
        bus.dst_y     = dy;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (phase) @(negedge clk);
        #1 reset = 1'b1;
        m_reset();
        #1 check_reset_state("midrst");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_nodone", 384'(bus.done), 384'(1'b0));
        end
        check("midrst_board_after", bus.board, m_flat());
    endtask

    initial begin
        logic [1:0] cmd;
        logic [5:0] pp;
        logic [2:0] sx, sy, dx, dy;
        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.clear_win   = 1'b0;
        bus.command     = 2'b00;
        bus.src_x       = 3'd0;
        bus.src_y       = 3'd0;
        bus.dst_x       = 3'd0;
        bus.dst_y       = 3'd0;
        bus.place_piece = 6'd0;
        m_reset();
        #12 check_reset_state("rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("post_rst");

        // Place then move a piece.
        do_cmd(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 6'b001001, 1'b0, 1'b0);
        do_cmd(2'b00, 3'd0, 3'd0, 3'd1, 3'd0, 6'd0, 1'b0, 1'b0);
        check("cell1_moved", 384'(bus.board[6 +: 6]), 384'(6'b001001));
        check("cell0_blank", 384'(bus.board[0 +: 6]), 384'(6'b000000));

        // Team-1 piece takes team-0 flag.
        do_cmd(2'b11, 3'd0, 3'd0, 3'd3, 3'd3, 6'b000111, 1'b0, 1'b0);
        do_cmd(2'b11, 3'd0, 3'd0, 3'd3, 3'd2, 6'b000010, 1'b0, 1'b0);
        do_cmd(2'b00, 3'd3, 3'd3, 3'd3, 3'd2, 6'd0, 1'b0, 1'b0);
        check("flag_set", 384'(bus.win_flag), 384'(1'b1));
        check("flag_team", 384'(bus.win_team), 384'(1'b1));
        do_clear();

        // Rejected commands leave the board intact.
        do_cmd(2'b00, 3'd1, 3'd0, 3'd2, 3'd3, 6'd0, 1'b0, 1'b0);
        do_cmd(2'b00, 3'd1, 3'd0, 3'd1, 3'd0, 6'd0, 1'b0, 1'b0);
        do_cmd(2'b11, 3'd0, 3'd0, 3'd1, 3'd0, 6'b010100, 1'b0, 1'b0);

        // Trade and die, with cmd_valid held through the busy window.
        do_cmd(2'b11, 3'd0, 3'd0, 3'd4, 3'd4, 6'b000100, 1'b1, 1'b0);
        do_cmd(2'b11, 3'd0, 3'd0, 3'd4, 3'd5, 6'b000101, 1'b1, 1'b0);
        do_cmd(2'b10, 3'd4, 3'd4, 3'd4, 3'd5, 6'd0, 1'b1, 1'b0);
        do_cmd(2'b11, 3'd0, 3'd0, 3'd0, 3'd1, 6'b001110, 1'b1, 1'b0);
        do_cmd(2'b01, 3'd0, 3'd1, 3'd0, 3'd2, 6'd0, 1'b1, 1'b0);

        // Flag capture with clear_win landing on the same edge.
        do_cmd(2'b11, 3'd0, 3'd0, 3'd6, 3'd6, 6'b000011, 1'b0, 1'b0);
        do_cmd(2'b11, 3'd0, 3'd0, 3'd6, 3'd7, 6'b001000, 1'b0, 1'b0);
        do_cmd(2'b00, 3'd6, 3'd7, 3'd6, 3'd6, 6'd0, 1'b0, 1'b1);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 4) cmd = 2'b11;
            else                          cmd = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                sx = 3'($urandom_range(0, 3)); sy = 3'($urandom_range(0, 3));
                dx = 3'($urandom_range(0, 3)); dy = 3'($urandom_range(0, 3));
            end else begin
                sx = 3'($urandom); sy = 3'($urandom);
                dx = 3'($urandom); dy = 3'($urandom);
            end
            if ($urandom_range(0, 2) == 0) pp = {5'd1, 1'($urandom)};
            else                           pp = 6'($urandom);
            do_cmd(cmd, sx, sy, dx, dy, pp, 1'($urandom), $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 24) == 0) do_clear();
            if (n == 80)  do_reset_mid(1'b0, 3'd0, 3'd0, 3'd1, 3'd0);
            if (n == 140) do_reset_mid(1'b1, 3'd1, 3'd1, 3'd2, 3'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
